// File: rtl/usb_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_pkg
//
// Purpose:
//   Shared timing constants and helpers for the USB receive bit timer.
//   The defaults describe full-speed reception with an 8x oversampling
//   clock: 8 system clocks per bit, sample taken at phase 3, 8-bit bytes,
//   8-byte blocks and a maximum of 7 transition-free samples before the
//   receiver is considered out of sync.
//
// Contents:
//   USB_CLKS_PER_BIT   default system clocks per USB bit period
//   USB_SAMPLE_PHASE   default phase value at which a bit is sampled
//   USB_BITS_PER_BYTE  default data bits per byte
//   USB_BLOCK_BYTES    default bytes per block
//   USB_MAX_RUN        default transition-free samples before sync loss
//   usb_phase_t        phase counter type for the default bit period
//   cnt_width()        counter width for a given modulus, never below 1
// ---------------------------------------------------------------------------
package usb_rx_pkg;

    localparam int USB_CLKS_PER_BIT  = 8;
    localparam int USB_SAMPLE_PHASE  = 3;
    localparam int USB_BITS_PER_BYTE = 8;
    localparam int USB_BLOCK_BYTES   = 8;
    localparam int USB_MAX_RUN       = 7;

    // A counter that only ever holds 0 still needs one bit of storage,
    // so the width is clamped at 1 for a modulus of 1.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    localparam int USB_PHASE_W = cnt_width(USB_CLKS_PER_BIT);

    typedef logic [USB_PHASE_W-1:0] usb_phase_t;

endpackage

// File: rtl/usb_rx_bit_timer_if.sv
// ---------------------------------------------------------------------------
// usb_rx_bit_timer_if
//
// Purpose:
//   Bundles the signals between the edge detector / receive controller and
//   the receive bit timer.
//
// Signals:
//   d_edge          one-cycle pulse, transition seen on the data line
//   rcving          packet reception active; low clears all timing state
//   stuff_skip      qualifies shift_enable: current bit is a stuffed bit
//   shift_enable    one-cycle sample strobe
//   byte_received   one-cycle pulse, a full byte of data bits collected
//   block_received  one-cycle pulse, a full block of bytes collected
//   bit_idx         data bits collected in the current byte
//   byte_cnt        bytes collected in the current block
//   sync_err        sticky loss-of-sync flag
//
// Modports:
//   master  the receive controller side (drives d_edge/rcving/stuff_skip)
//   slave   the bit timer itself
// ---------------------------------------------------------------------------
interface usb_rx_bit_timer_if #(
    parameter int BITS_PER_BYTE = usb_rx_pkg::USB_BITS_PER_BYTE,
    parameter int BLOCK_BYTES   = usb_rx_pkg::USB_BLOCK_BYTES
);

    localparam int BIT_W  = usb_rx_pkg::cnt_width(BITS_PER_BYTE);
    localparam int BYTE_W = usb_rx_pkg::cnt_width(BLOCK_BYTES);

    logic              d_edge;
    logic              rcving;
    logic              stuff_skip;
    logic              shift_enable;
    logic              byte_received;
    logic              block_received;
    logic [BIT_W-1:0]  bit_idx;
    logic [BYTE_W-1:0] byte_cnt;
    logic              sync_err;

    modport master (
        output d_edge,
        output rcving,
        output stuff_skip,
        input  shift_enable,
        input  byte_received,
        input  block_received,
        input  bit_idx,
        input  byte_cnt,
        input  sync_err
    );

    modport slave (
        input  d_edge,
        input  rcving,
        input  stuff_skip,
        output shift_enable,
        output byte_received,
        output block_received,
        output bit_idx,
        output byte_cnt,
        output sync_err
    );

endinterface

// File: rtl/usb_rx_bit_timer_wrap_counter.sv
// ---------------------------------------------------------------------------
// rx_wrap_counter
//
// Purpose:
//   Modulo-N up counter used for the bit phase, the bit index within a
//   byte and the byte index within a block. Counts 0..MODULUS-1 and wraps.
//
// Ports:
//   clk     system clock
//   n_rst   asynchronous active-low reset
//   clear   synchronous clear, wins over enable
//   enable  advance the count by one this cycle
//   count   current count value
//   wrap    combinational strobe: this enabled step takes count back to 0
// ---------------------------------------------------------------------------
module rx_wrap_counter
    import usb_rx_pkg::*;
#(
    parameter int MODULUS = 8,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    // Terminal value compared at the counter's own width.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic at_last;

    assign at_last = (count == LAST);

    // The wrap strobe is only meaningful on a step that actually advances
    // the counter, so a pending clear masks it.
    assign wrap = enable & ~clear & at_last;

    // Count register: clear has priority, otherwise step and wrap at the
    // terminal value. Non-power-of-two moduli never see the unused codes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// usb_rx_bit_timer
//
// Purpose:
//   Receive bit timing for the USB receiver path. A free-running phase
//   counter is realigned by every data-line transition and produces one
//   sample strobe per bit period. Counted (non-stuffed) samples are
//   gathered into bytes and bytes into blocks. A run counter watches for
//   too many samples without a transition and raises a sticky sync error,
//   which freezes byte/block counting until reception is dropped.
//
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    usb_rx_bit_timer_if slave modport:
//            in : d_edge, rcving, stuff_skip
//            out: shift_enable, byte_received, block_received,
//                 bit_idx, byte_cnt, sync_err
// ---------------------------------------------------------------------------
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE  = USB_SAMPLE_PHASE,
    parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
    parameter int BLOCK_BYTES   = USB_BLOCK_BYTES,
    parameter int MAX_RUN_BITS  = USB_MAX_RUN
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_rx_bit_timer_if.slave  bus
);

    localparam int PHASE_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W   = cnt_width(BITS_PER_BYTE);
    localparam int BYTE_W  = cnt_width(BLOCK_BYTES);
    // The run counter must be able to hold MAX_RUN_BITS itself.
    localparam int RUN_W   = cnt_width(MAX_RUN_BITS + 1);

    localparam logic [PHASE_W-1:0] SAMPLE_AT = PHASE_W'(SAMPLE_PHASE);
    localparam logic [RUN_W-1:0]   RUN_LIMIT = RUN_W'(MAX_RUN_BITS);

    logic [PHASE_W-1:0] phase;
    logic [BIT_W-1:0]   bit_idx_q;
    logic [BYTE_W-1:0]  byte_cnt_q;
    logic [RUN_W-1:0]   run_q;
    logic               sync_err_q;
    logic               byte_pulse_q;
    logic               block_pulse_q;

    logic               phase_clear;
    logic               phase_wrap_unused;
    logic               shift_en;
    logic               counted;
    logic               timing_clear;
    logic               bit_wrap;
    logic               byte_wrap;
    logic               run_at_limit;

    // Phase realignment: any transition restarts the bit period so the
    // sample point tracks the transmitter's clock.
    assign phase_clear  = ~bus.rcving | bus.d_edge;
    assign timing_clear = ~bus.rcving;

    // The phase counter's wrap strobe has no consumer; the sample point is
    // decoded from the count. A transition in the sample cycle still lets
    // that sample through and only moves the next one.
    assign shift_en = bus.rcving & (phase == SAMPLE_AT);

    // Stuffed bits and anything seen after sync loss are not data.
    assign counted = shift_en & ~bus.stuff_skip & ~sync_err_q;

    assign run_at_limit = (run_q == RUN_LIMIT);

    rx_wrap_counter #(
        .MODULUS (CLKS_PER_BIT),
        .WIDTH   (PHASE_W)
    ) u_phase_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (phase_clear),
        .enable (1'b1),
        .count  (phase),
        .wrap   (phase_wrap_unused)
    );

    rx_wrap_counter #(
        .MODULUS (BITS_PER_BYTE),
        .WIDTH   (BIT_W)
    ) u_bit_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (timing_clear),
        .enable (counted),
        .count  (bit_idx_q),
        .wrap   (bit_wrap)
    );

    // The byte counter steps once per completed byte, so its wrap marks
    // the last byte of a block landing on the same edge as that byte.
    rx_wrap_counter #(
        .MODULUS (BLOCK_BYTES),
        .WIDTH   (BYTE_W)
    ) u_byte_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (timing_clear),
        .enable (bit_wrap),
        .count  (byte_cnt_q),
        .wrap   (byte_wrap)
    );

    // Registered completion pulses, one cycle after the final counted
    // sample. bit_wrap already implies rcving high and no sync error, so
    // dropping reception or losing sync forces both pulses low.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_pulse_q  <= 1'b0;
            block_pulse_q <= 1'b0;
        end else begin
            byte_pulse_q  <= bit_wrap;
            block_pulse_q <= byte_wrap;
        end
    end

    // Run-length watchdog. A transition empties the run even when it lands
    // on a sample; otherwise each sample adds one, saturating at the limit.
    // A further transition-free sample at the limit latches sync_err,
    // which only clears when reception is dropped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run_q      <= '0;
            sync_err_q <= 1'b0;
        end else if (!bus.rcving) begin
            run_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            if (bus.d_edge) begin
                run_q <= '0;
            end else if (shift_en && !run_at_limit) begin
                run_q <= run_q + 1'b1;
            end

            if (shift_en && !bus.d_edge && run_at_limit) begin
                sync_err_q <= 1'b1;
            end
        end
    end

    assign bus.shift_enable   = shift_en;
    assign bus.byte_received  = byte_pulse_q;
    assign bus.block_received = block_pulse_q;
    assign bus.bit_idx        = bit_idx_q;
    assign bus.byte_cnt       = byte_cnt_q;
    assign bus.sync_err       = sync_err_q;

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_bit_timer
//
// Purpose:
//   Self-checking bench for usb_rx_bit_timer with default parameters.
//   Each directed scenario pushes its hand-derived sample and byte events
//   (absolute cycle, bit_idx, byte_cnt, block flag) into a scoreboard
//   queue; an independent monitor pops and compares whenever the DUT
//   raises shift_enable or byte_received. State checks (reset, sync_err,
//   clearing on rcving low) are made directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_usb_rx_bit_timer;
    import usb_rx_pkg::*;

    typedef struct {
        int cyc;
        bit is_byte;
        int bit_idx;
        int byte_cnt;
        bit block;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   base         = 0;
    int   edge_list[$];
    int   stuff_list[$];
    exp_t exp_q[$];

    usb_rx_bit_timer_if bus ();

    usb_rx_bit_timer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void push_sample(input int rel, input int bidx);
        exp_t e;
        e.cyc = base + rel; e.is_byte = 1'b0; e.bit_idx = bidx; e.byte_cnt = 0; e.block = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_byte(input int rel, input int bcnt, input bit blk);
        exp_t e;
        e.cyc = base + rel; e.is_byte = 1'b1; e.bit_idx = 0; e.byte_cnt = bcnt; e.block = blk;
        exp_q.push_back(e);
    endfunction

    // Drive one packet of n_cycles with rcving high; d_edge / stuff_skip
    // pulse on the relative cycles listed in edge_list / stuff_list.
    task automatic applyStimulus(input int n_cycles);
        bus.rcving = 1'b1;
        for (int c = 0; c < n_cycles; c++) begin
            bus.d_edge     = 1'b0;
            bus.stuff_skip = 1'b0;
            for (int i = 0; i < edge_list.size(); i++)
                if (edge_list[i] == c) bus.d_edge = 1'b1;
            for (int i = 0; i < stuff_list.size(); i++)
                if (stuff_list[i] == c) bus.stuff_skip = 1'b1;
            @(posedge clk); #1;
        end
        bus.d_edge     = 1'b0;
        bus.stuff_skip = 1'b0;
    endtask

    // Drop rcving; one edge later all timing state must be clear.
    task automatic end_packet(input string tag);
        bus.rcving = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, "_clr_sync_err"}, int'(bus.sync_err), 0);
        checkOutput({tag, "_clr_bit_idx"},  int'(bus.bit_idx), 0);
        checkOutput({tag, "_clr_byte_cnt"}, int'(bus.byte_cnt), 0);
        @(posedge clk); #1;
    endtask

    task automatic start_packet();
        edge_list.delete();
        stuff_list.delete();
        base = cyc;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst === 1'b1) begin
            if (bus.shift_enable) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_sample_at_cycle", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sample_kind", int'(e.is_byte), 0);
                    checkOutput("sample_cycle", cyc, e.cyc);
                    checkOutput("sample_bit_idx", int'(bus.bit_idx), e.bit_idx);
                end
            end
            if (bus.byte_received) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte_at_cycle", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("byte_kind", int'(e.is_byte), 1);
                    checkOutput("byte_cycle", cyc, e.cyc);
                    checkOutput("byte_bit_idx", int'(bus.bit_idx), e.bit_idx);
                    checkOutput("byte_byte_cnt", int'(bus.byte_cnt), e.byte_cnt);
                    checkOutput("byte_block", int'(bus.block_received), int'(e.block));
                end
            end else if (bus.block_received) begin
                checkOutput("stray_block_received", 1, 0);
            end
        end
    end

    initial begin
        n_rst          = 1'b0;
        bus.rcving     = 1'b0;
        bus.d_edge     = 1'b0;
        bus.stuff_skip = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_shift_enable",   int'(bus.shift_enable), 0);
        checkOutput("rst_byte_received",  int'(bus.byte_received), 0);
        checkOutput("rst_block_received", int'(bus.block_received), 0);
        checkOutput("rst_bit_idx",        int'(bus.bit_idx), 0);
        checkOutput("rst_byte_cnt",       int'(bus.byte_cnt), 0);
        checkOutput("rst_sync_err",       int'(bus.sync_err), 0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: no edges, samples at 3+8k, byte at 60; the 8th sample also
        //    meets the run limit, so sync_err is up afterwards.
        $display("[TB] scenario 1: free-running sample timing");
        start_packet();
        for (int k = 0; k < 8; k++) push_sample(3 + 8 * k, k);
        push_byte(60, 1, 1'b0);
        applyStimulus(61);
        checkOutput("t1_sync_err", int'(bus.sync_err), 1);
        end_packet("t1");

        // 2: edge at 5 realigns: samples 3, then 9, 17, ... 57; byte at 58.
        $display("[TB] scenario 2: edge realignment");
        start_packet();
        edge_list.push_back(5);
        push_sample(3, 0);
        for (int k = 1; k < 8; k++) push_sample(1 + 8 * k, k);
        push_byte(58, 1, 1'b0);
        applyStimulus(59);
        checkOutput("t2_sync_err", int'(bus.sync_err), 0);
        end_packet("t2");

        // 3: 4th sample (cycle 27) stuffed; 9 samples per byte, byte at 68.
        $display("[TB] scenario 3: stuffed bit");
        start_packet();
        stuff_list.push_back(27);
        edge_list.push_back(31);
        for (int k = 0; k < 9; k++) push_sample(3 + 8 * k, (k <= 3) ? k : k - 1);
        push_byte(68, 1, 1'b0);
        applyStimulus(69);
        end_packet("t3");

        // 4: full block, edges every 2 bits on bit boundaries.
        $display("[TB] scenario 4: full block");
        start_packet();
        for (int m = 0; m < 32; m++) edge_list.push_back(15 + 16 * m);
        for (int k = 0; k < 64; k++) begin
            push_sample(3 + 8 * k, k % 8);
            if (k % 8 == 7) push_byte(4 + 8 * k, ((k / 8) + 1) % 8, k == 63);
        end
        applyStimulus(509);
        checkOutput("t4_byte_cnt", int'(bus.byte_cnt), 0);
        checkOutput("t4_sync_err", int'(bus.sync_err), 0);
        end_packet("t4");

        // 5: last edge at 15; sync lost on the 8th edge-free sample (75),
        //    bit_idx then frozen at 2 while samples keep coming.
        $display("[TB] scenario 5: loss of sync");
        start_packet();
        edge_list.push_back(15);
        for (int k = 0; k < 18; k++) begin
            push_sample(3 + 8 * k, (k <= 9) ? (k % 8) : 2);
            if (k == 7) push_byte(60, 1, 1'b0);
        end
        applyStimulus(141);
        checkOutput("t5_sync_err",  int'(bus.sync_err), 1);
        checkOutput("t5_bit_idx",   int'(bus.bit_idx), 2);
        checkOutput("t5_byte_cnt",  int'(bus.byte_cnt), 1);
        end_packet("t5");

        // 6: async reset with bit_idx at 5, then a clean restart.
        $display("[TB] scenario 6: reset mid-byte");
        start_packet();
        for (int k = 0; k < 5; k++) push_sample(3 + 8 * k, k);
        applyStimulus(38);
        checkOutput("t6_pre_bit_idx", int'(bus.bit_idx), 5);
        n_rst      = 1'b0;
        bus.rcving = 1'b0;
        #1;
        checkOutput("t6_async_bit_idx",      int'(bus.bit_idx), 0);
        checkOutput("t6_async_byte_cnt",     int'(bus.byte_cnt), 0);
        checkOutput("t6_async_sync_err",     int'(bus.sync_err), 0);
        checkOutput("t6_async_byte_rcvd",    int'(bus.byte_received), 0);
        checkOutput("t6_async_shift_enable", int'(bus.shift_enable), 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        start_packet();
        push_sample(3, 0);
        push_sample(11, 1);
        applyStimulus(13);
        checkOutput("t6_restart_bit_idx", int'(bus.bit_idx), 2);
        end_packet("t6");

        checkOutput("scoreboard_leftover", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_timer.md
Name: usb_rx_bit_timer

Overview:
Parametrised receive bit-timing block for the USB receiver path. It recovers the bit sample point from data-line edges and qualifies samples against bit-stuffing. It counts bits into bytes and bytes into blocks, and flags loss of bit synchronisation when the line goes too long without a transition. It sits between the edge detector and the shift register / receive controller, replacing the fixed 8-clock, 8-bit, 8-byte timer.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit period (>=4)
SAMPLE_PHASE, 3, phase value at which a bit is sampled (0..CLKS_PER_BIT-1)
BITS_PER_BYTE, 8, data bits per byte (stuffed bits excluded)
BLOCK_BYTES, 8, bytes per block (block_received period)
MAX_RUN_BITS, 7, max consecutive samples without a line edge before sync error

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_edge  input  1  one-cycle pulse: transition detected on data line
rcving  input  1  packet reception active; low clears all timing state
stuff_skip  input  1  valid with shift_enable: current bit is a stuffed bit, not counted
shift_enable  output  1  one-cycle sample strobe
byte_received  output  1  registered one-cycle pulse: BITS_PER_BYTE data bits complete
block_received  output  1  registered one-cycle pulse: BLOCK_BYTES bytes complete
bit_idx  output  $clog2(BITS_PER_BYTE)  data bits collected in current byte
byte_cnt  output  $clog2(BLOCK_BYTES)  bytes collected in current block
sync_err  output  1  sticky loss-of-sync flag

Behaviour:
- Reset (n_rst low, async): phase, bit_idx, byte_cnt, run counter, byte_received, block_received and sync_err all go to 0 immediately.
- Phase counter:
  - If !rcving or d_edge: phase <= 0.
  - Otherwise phase <= (phase==CLKS_PER_BIT-1) ? 0 : phase+1.
- shift_enable = rcving & (phase==SAMPLE_PHASE), combinational from registered phase.
  - A d_edge in the same cycle does not suppress the current sample. It only resets phase for the next cycle.
- Counting takes a counted sample only: shift_enable & !stuff_skip & !sync_err.
  - bit_idx increments; at BITS_PER_BYTE-1 it wraps to 0 and byte_received is set for exactly the next cycle.
  - On that same wrap, byte_cnt increments. At BLOCK_BYTES-1 it wraps to 0 and block_received is set on the same cycle as byte_received.
- Stuffed sample (shift_enable & stuff_skip): bit_idx and byte_cnt unchanged. The run counter still updates.
- Run counter:
  - d_edge sets it to 0; this takes priority over a simultaneous shift_enable.
  - Otherwise shift_enable increments it, saturating at MAX_RUN_BITS.
  - A shift_enable with no d_edge while run==MAX_RUN_BITS sets sync_err.
- sync_err:
  - Stays set while rcving is high and suppresses byte_received / block_received and counting.
  - shift_enable keeps toggling during sync_err.
  - rcving low clears sync_err on the next edge.
- rcving low: next edge clears phase, bit_idx, byte_cnt, run counter and sync_err. The pulse outputs are 0 that cycle.
- Latency: shift_enable occurs SAMPLE_PHASE+1 cycles after the d_edge cycle. byte_received / block_received follow the final counted shift_enable by 1 cycle.
- Width rules: all counters are sized with $clog2 of their modulus, minimum 1 bit. Equality compares are done at counter width; no 32-bit counters.

Decomposition:
- Package usb_rx_pkg: default timing constants (USB_CLKS_PER_BIT=8, USB_SAMPLE_PHASE=3, USB_MAX_RUN=7) and a typedef for the phase width.
- One sub-module, rx_wrap_counter (parametrised modulus, clear, enable, wrap strobe), instantiated for phase, bit and byte counting.
- The run counter and sync logic stay inline.

Test Plan:
1. rcving 0→1 at cycle 0, no d_edge -> shift_enable at cycles 3, 11, 19, ...; byte_received at cycle 60 (8th sample at 59 + 1).
2. d_edge pulse at cycle 5 of a running packet -> phase 0 at cycle 6, next shift_enable at cycle 9, then every 8 cycles.
3. stuff_skip high on the 4th sample -> byte_received delayed by one bit period (9 samples per byte); bit_idx holds at 3 across the stuffed sample.
4. 64 counted samples with edges every 2 bits -> 8 byte_received pulses; block_received coincides with the 8th; byte_cnt returns to 0.
5. Edges stop after bit 2 -> sync_err rises on the 8th edge-free sample; no further byte_received; rcving low clears sync_err next cycle.
6. n_rst pulled low mid-byte (bit_idx=5) -> all outputs 0 asynchronously; after release and rcving high, counting restarts from bit_idx=0.
